// File: rtl/scan_seq_pkg.sv
// rtl/scan_seq_pkg.sv - shared state encoding, angle limits and error bit positions for the scan sequencer
package scan_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int unsigned ERR_TIMEOUT     = 0;
  localparam int unsigned ERR_SKIP        = 1;
  localparam int unsigned ERR_CFG         = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 3200;

  // Highest encoder index per revolution for each resolution mode.
  function automatic logic [15:0] max_angle(input logic [1:0] mode);
    case (mode)
      2'd0:    return 16'd4211;
      2'd1:    return 16'd2105;
      2'd2:    return 16'd1053;
      default: return 16'd526;
    endcase
  endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// rtl/scan_seq_ctrl_if.sv - encoder angle stream into the scan sequencer
interface scan_seq_ctrl_if;
  logic [15:0] i_code_angle;
  logic        i_tdc_new_sig;

  modport master (output i_code_angle, output i_tdc_new_sig);
  modport slave  (input  i_code_angle, input  i_tdc_new_sig);
endinterface

// File: rtl/scan_seq_ctrl_angle_watchdog.sv
// rtl/scan_seq_ctrl_angle_watchdog.sv - flags a stalled angle strobe after TIMEOUT_CYC idle cycles
module angle_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 3200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic timeout_o
);
  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q;

  // Saturates at the limit so the flag stays up until the owner leaves the counting states.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i || clr_i) begin
      cnt_q <= '0;
    end else if (!timeout_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign timeout_o = en_i && (cnt_q == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/scan_seq_ctrl.sv
// rtl/scan_seq_ctrl.sv - per-revolution scan sequencer driving TDC and measure enables
module scan_seq_ctrl
  import scan_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk_50m,
  input  logic             i_rst_n,
  input  logic [1:0]       i_reso_mode,
  input  logic             i_motor_state,
  input  logic             i_measure_req,
  input  logic             i_err_clr,
  scan_seq_ctrl_if.slave   angle_if,
  input  logic [15:0]      i_start_index,
  input  logic [15:0]      i_stop_index,
  output logic             o_tdc_switch,
  output logic             o_measure_en,
  output logic             o_scan_start,
  output logic             o_scan_done,
  output logic [CNT_W-1:0] o_scan_counter,
  output logic [2:0]       o_ctrl_error,
  output logic [1:0]       o_state
);
  state_e           state_q;
  logic             tdc_d_q;
  logic             tdc_switch_q;
  logic             measure_en_q;
  logic             scan_start_q;
  logic             scan_done_q;
  logic [15:0]      prev_q;
  logic [15:0]      max_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [2:0]       err_q;

  logic        ev;
  logic        start_req;
  logic        cfg_ok;
  logic        active;
  logic        wd_to;
  logic        angle_ok;
  logic [15:0] max_live;
  logic [15:0] expected;
  logic [2:0]  err_set;

  assign ev        = angle_if.i_tdc_new_sig & ~tdc_d_q;
  assign max_live  = max_angle(i_reso_mode);
  assign cfg_ok    = (i_start_index <= i_stop_index) && (i_stop_index <= max_live);
  assign start_req = i_motor_state & i_measure_req;
  assign active    = (state_q == ST_SYNC) || (state_q == ST_RUN);
  assign expected  = (prev_q == max_q) ? 16'd0 : prev_q + 16'd1;
  assign angle_ok  = (angle_if.i_code_angle == expected);

  // Error sources follow the same priority chain as the FSM below.
  always_comb begin
    err_set              = '0;
    err_set[ERR_CFG]     = (state_q == ST_IDLE) && start_req && !cfg_ok;
    err_set[ERR_TIMEOUT] = active && i_motor_state && wd_to;
    err_set[ERR_SKIP]    = (state_q == ST_RUN) && i_motor_state && !wd_to && ev && !angle_ok;
  end

  angle_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wd (
    .clk_i     (i_clk_50m),
    .rst_ni    (i_rst_n),
    .en_i      (active),
    .clr_i     (ev),
    .timeout_o (wd_to)
  );

  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      tdc_d_q      <= 1'b0;
      tdc_switch_q <= 1'b0;
      measure_en_q <= 1'b0;
      scan_start_q <= 1'b0;
      scan_done_q  <= 1'b0;
      prev_q       <= '0;
      max_q        <= '0;
      scan_cnt_q   <= '0;
      err_q        <= '0;
    end else begin
      tdc_d_q      <= angle_if.i_tdc_new_sig;
      scan_start_q <= 1'b0;
      scan_done_q  <= 1'b0;
      err_q        <= (i_err_clr ? 3'b000 : err_q) | err_set;
      case (state_q)
        ST_IDLE: begin
          tdc_switch_q <= 1'b0;
          measure_en_q <= 1'b0;
          // Angle range is frozen here so mid-scan mode changes cannot break wrap detection.
          if (start_req && cfg_ok) begin
            state_q      <= ST_SYNC;
            tdc_switch_q <= 1'b1;
            max_q        <= max_live;
          end
        end
        ST_SYNC, ST_RUN: begin
          if (!i_motor_state) begin
            state_q      <= ST_IDLE;
            tdc_switch_q <= 1'b0;
            measure_en_q <= 1'b0;
          end else if (wd_to) begin
            state_q      <= ST_FAULT;
            tdc_switch_q <= 1'b0;
            measure_en_q <= 1'b0;
          end else if (ev) begin
            if (state_q == ST_SYNC) begin
              if (angle_if.i_code_angle == 16'd0) begin
                state_q      <= ST_RUN;
                measure_en_q <= 1'b1;
                scan_start_q <= 1'b1;
                prev_q       <= '0;
              end
            end else if (!angle_ok) begin
              state_q      <= ST_SYNC;
              measure_en_q <= 1'b0;
            end else if (expected != 16'd0) begin
              prev_q <= angle_if.i_code_angle;
            end else begin
              scan_done_q <= 1'b1;
              scan_cnt_q  <= scan_cnt_q + CNT_W'(1);
              prev_q      <= '0;
              if (i_measure_req) begin
                scan_start_q <= 1'b1;
              end else begin
                state_q      <= ST_IDLE;
                tdc_switch_q <= 1'b0;
                measure_en_q <= 1'b0;
              end
            end
          end
        end
        ST_FAULT: begin
          tdc_switch_q <= 1'b0;
          measure_en_q <= 1'b0;
          if (!i_measure_req) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tdc_switch   = tdc_switch_q;
  assign o_measure_en   = measure_en_q;
  assign o_scan_start   = scan_start_q;
  assign o_scan_done    = scan_done_q;
  assign o_scan_counter = scan_cnt_q;
  assign o_ctrl_error   = err_q;
  assign o_state        = state_q;
endmodule

// File: doc/scan_seq_ctrl.md
Name: scan_seq_ctrl

Overview:
Per-revolution sequencer in front of the tdc_process → dist_filter → dist_packet chain. It watches the encoder angle stream (i_code_angle with i_tdc_new_sig) and drives the TDC enable and measurement enable. It brackets each revolution with scan start/done pulses and counts scans. It also detects angle skips, lost angle strobes and bad index configuration, and in each case takes the chain out of measurement.

Parameters:
TIMEOUT_CYC, 3200, clock cycles with no i_tdc_new_sig edge (in SYNC/RUN) before a timeout fault
CNT_W, 16, width of scan counter

Ports:
i_clk_50m  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_reso_mode  in  2  resolution; sets max angle: 0→4211, 1→2105, 2→1053, 3→526
i_motor_state  in  1  1 = motor at speed
i_measure_req  in  1  host measurement request (level)
i_err_clr  in  1  one-cycle pulse, clears o_ctrl_error
i_code_angle  in  16  encoder angle index
i_tdc_new_sig  in  1  angle strobe; rising edge is the event
i_start_index  in  16  first reported index
i_stop_index  in  16  last reported index
o_tdc_switch  out  1  TDC processing enable
o_measure_en  out  1  dist_packet measure enable
o_scan_start  out  1  one-cycle pulse, revolution start
o_scan_done  out  1  one-cycle pulse, revolution complete
o_scan_counter  out  CNT_W  completed revolutions, wraps
o_ctrl_error  out  3  sticky: [0] timeout, [1] angle skip, [2] cfg invalid
o_state  out  2  current FSM state (debug)

Behaviour:
- Reset: all outputs 0; state IDLE; prev_angle 0; watchdog 0.
- The strobe is edge-detected with one register. "ev" = rising edge of i_tdc_new_sig.
- All outputs are registered. A response to an ev in cycle N appears in cycle N+1.
- max = mode table value, decoded combinationally from i_reso_mode.
- cfg_ok = (start ≤ stop) && (stop ≤ max).
- States (encoding in package): IDLE=0, SYNC=1, RUN=2, FAULT=3.
- IDLE:
  - tdc_switch=0, measure_en=0.
  - Go to SYNC when motor_state && measure_req && cfg_ok.
  - If motor_state && measure_req && !cfg_ok: set error[2] and stay in IDLE.
- SYNC:
  - tdc_switch=1, measure_en=0.
  - On ev with angle==0: go to RUN, pulse scan_start, set measure_en=1, prev_angle←0.
  - An ev with any other angle is ignored.
- RUN:
  - tdc_switch=1, measure_en=1.
  - On ev, expected = (prev==max) ? 0 : prev+1.
  - angle==expected, nonzero: prev←angle.
  - angle==expected==0 (wrap): pulse scan_done, counter+1.
    - If measure_req still high: pulse scan_start in the same cycle and stay in RUN.
    - Otherwise: go to IDLE with measure_en=0 (graceful stop at revolution boundary).
  - angle≠expected, including angle>max: set error[1], go to SYNC, measure_en=0 next cycle. No scan_done.
- Abort rule: motor_state=0 in SYNC/RUN → IDLE immediately, outputs off, no scan_done.
- Watchdog:
  - Counts in SYNC/RUN and clears on every ev.
  - Reaching TIMEOUT_CYC → set error[0] and go to FAULT.
  - Held at 0 in IDLE and FAULT.
- FAULT:
  - All enables 0.
  - Go to IDLE only when measure_req==0.
- Priority within one cycle: motor loss > timeout > ev processing > measure_req drop.
- Mode/config stability: i_reso_mode or index changes outside IDLE take effect only after returning to IDLE. Mode and indices are latched on IDLE→SYNC.
- Error register:
  - Bits are set-sticky.
  - i_err_clr clears all bits.
  - A set in the same cycle as a clear wins.
- Scan counter wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-operation: next edge forces the reset state; no pulses emitted.

Decomposition:
- Package scan_seq_pkg:
  - state encoding
  - max-angle table per reso mode
  - error bit indices
  - TIMEOUT_CYC default
- Sub-module angle_watchdog: counter with clear/enable/timeout flag, parameterised by TIMEOUT_CYC.

Test Plan:
- Mode 2, start 165, stop 915, req=1, motor=1, angles 0..1053 at one strobe per 1543 cycles:
  - first ev angle 0 → scan_start, measure_en=1
  - angle 1053→0 → scan_done and scan_start in the same cycle, counter=1
- Repeat the sequence with angle 500 skipped (499→501):
  - error[1]=1, measure_en=0, state SYNC
  - next angle 0 → RUN
- Stop strobes after angle 300 for 3200 cycles:
  - error[0]=1, state FAULT
  - req=0 → IDLE
  - err_clr → error=0
- Drop req at angle 600:
  - scan continues to wrap
  - scan_done pulses once, no scan_start, state IDLE
- Set stop=1100 in mode 2: error[2]=1, stays IDLE, tdc_switch=0. Drop motor_state mid-RUN: IDLE next cycle, no scan_done.
- Preload counter to 0xFFFF by running or forcing, complete one revolution: counter=0x0000. Assert reset during RUN: all outputs 0 next cycle.
